// File: rtl/score_bcd_reader.sv
// Converts the binary game score to packed BCD with a bit-serial double-dabble, then presents
// stable digits, a leading-zero mask and a one-cycle update strobe to the display side.
module score_bcd_reader #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      score_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_nz,
  output logic                  update_stb,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    last_val_q, last_val_d;
  logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
  logic [BcdW-1:0]     bcd_sr_q, bcd_sr_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                sat_q, sat_d;
  logic [BcdW-1:0]     digits_q, digits_d;
  logic [DIGITS-1:0]   nz_q, nz_d;
  logic                stb_q, stb_d;
  logic                ovf_q, ovf_d;

  logic [BcdW-1:0]     bcd_adj;
  logic [BcdW-1:0]     digits_new;
  logic [DIGITS-1:0]   nz_new;

  always_comb begin
    bcd_adj = bcd_sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
    end

    digits_new = sat_q ? {DIGITS{4'h9}} : bcd_sr_q;
    // A digit is shown if it or any more significant digit is non-zero; ones always shown.
    nz_new = '0;
    nz_new[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      nz_new[i] = |(digits_new >> (4 * i));
    end
  end

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    bin_sr_d   = bin_sr_q;
    bcd_sr_d   = bcd_sr_q;
    bit_cnt_d  = bit_cnt_q;
    sat_d      = sat_q;
    digits_d   = digits_q;
    nz_d       = nz_q;
    stb_d      = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      StIdle: begin
        if (score_in != last_val_q) begin
          last_val_d = score_in;
          if (score_in > MaxVal) begin
            sat_d   = 1'b1;
            state_d = StDone;
          end else begin
            bin_sr_d  = score_in;
            bcd_sr_d  = '0;
            bit_cnt_d = CntW'(WIDTH);
            sat_d     = 1'b0;
            state_d   = StShift;
          end
        end
      end
      StShift: begin
        bcd_sr_d  = {bcd_adj[BcdW-2:0], bin_sr_q[WIDTH-1]};
        bin_sr_d  = {bin_sr_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - CntW'(1);
        if (bit_cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        digits_d = digits_new;
        nz_d     = nz_new;
        ovf_d    = sat_q;
        stb_d    = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      last_val_q <= '0;
      bin_sr_q   <= '0;
      bcd_sr_q   <= '0;
      bit_cnt_q  <= '0;
      sat_q      <= 1'b0;
      digits_q   <= '0;
      nz_q       <= DIGITS'(1);
      stb_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      bin_sr_q   <= bin_sr_d;
      bcd_sr_q   <= bcd_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      sat_q      <= sat_d;
      digits_q   <= digits_d;
      nz_q       <= nz_d;
      stb_q      <= stb_d;
      ovf_q      <= ovf_d;
    end
  end

  assign digits_out = digits_q;
  assign digit_nz   = nz_q;
  assign update_stb = stb_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_score_bcd_reader.sv
// Scoreboard bench for score_bcd_reader: each score change pushes the expected digits and the
// edge at which they must appear; the monitor pops and compares on every update strobe.
module tb_score_bcd_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] score_in = '0;
  logic [15:0] digits_out;
  logic [3:0]  digit_nz;
  logic        update_stb;
  logic        overflow;
  logic        busy;

  score_bcd_reader #(.WIDTH(32), .DIGITS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .score_in   (score_in),
    .digits_out (digits_out),
    .digit_nz   (digit_nz),
    .update_stb (update_stb),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  nz;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rst_edge = 1'b1;
  logic        prev_stb = 1'b0;
  logic [20:0] prev_vec = '0;
  logic [31:0] cur_score = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    rst_edge = reset;
  end

  always @(negedge clock) begin
    if (update_stb) begin
      if (sb.size() == 0) begin
        check("spurious_stb", 32'(update_stb), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("digits", 32'(digits_out), 32'(e.d));
        check("digit_nz", 32'(digit_nz), 32'(e.nz));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("latency", 32'(cyc), 32'(e.at));
      end
      check("stb_pulse", 32'(prev_stb), 32'd0);
    end else if (!rst_edge) begin
      check("stable", 32'({digits_out, digit_nz, overflow}), 32'(prev_vec));
    end
    prev_stb = update_stb;
    prev_vec = {digits_out, digit_nz, overflow};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Expected display for a score, computed by decimal division.
  task automatic push_exp(input logic [31:0] v, input int at);
    exp_t        e;
    int unsigned r;
    if (v > 32'd9999) begin
      e.d   = 16'h9999;
      e.nz  = 4'hf;
      e.ovf = 1'b1;
    end else begin
      r = v;
      e.d = '0;
      for (int i = 0; i < 4; i++) begin
        e.d[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
      e.nz = 4'b0001;
      for (int i = 1; i < 4; i++) e.nz[i] = (v >= 32'(10 ** i));
      e.ovf = 1'b0;
    end
    e.at = at;
    sb.push_back(e);
  endtask

  // Drive a new score while the DUT is idle; sampled at the next edge (E0).
  task automatic drive(input logic [31:0] v);
    score_in  = v;
    cur_score = v;
    push_exp(v, cyc + 1 + ((v > 32'd9999) ? 1 : 33));
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) step(1);
    check("drain", 32'(sb.size()), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [31:0] v;

    // Reset with score 0, then hold: no conversion may run.
    step(3);
    reset = 1'b0;
    step(100);
    check("rst_digits", 32'(digits_out), 32'h0);
    check("rst_nz", 32'(digit_nz), 32'h1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    drive(32'd12);
    drain(60);

    drive(32'd9999);
    drain(60);
    drive(32'd10000);
    drain(10);
    drive(32'hffff_ffff);
    drain(10);

    drive(32'd1005);
    drain(60);

    drive(32'd0);
    drain(60);

    // Change while shifting: ignored until the conversion finishes, then re-sampled.
    drive(32'd5);
    drain(60);
    t0 = cyc;
    drive(32'd7);
    step(10);
    check("busy_shift", 32'(busy), 32'd1);
    score_in  = 32'd8;
    cur_score = 32'd8;
    push_exp(32'd8, t0 + 68);
    drain(120);

    // Reset mid-conversion discards it.
    drive(32'd50);
    step(14);
    reset    = 1'b1;
    score_in = 32'd3;
    step(1);
    sb.delete();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_digits", 32'(digits_out), 32'h0);
    check("midrst_nz", 32'(digit_nz), 32'h1);
    reset     = 1'b0;
    cur_score = 32'd3;
    push_exp(32'd3, cyc + 34);
    drain(60);

    for (int k = 0; k < 8; k++) begin
      v = 32'($urandom_range(0, 12000));
      if (v == cur_score) v = v + 32'd1;
      drive(v);
      drain(60);
    end

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
